// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vga_pkg
//  Description : Screen geometry, coordinate/colour widths and the sprite
//                plotter state type shared by the VGA pixel pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COLOUR_W = 3;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_plotter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sprite_plotter_if
//  Description : Request, sprite-ROM and pixel-output signals between the
//                animation controller (master) and the sprite plotter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_plotter_if;
   import vga_pkg::*;

   logic                go;
   logic                erase;
   logic [X_W-1:0]      x_in;
   logic [Y_W-1:0]      y_in;
   logic [7:0]          rom_addr;
   logic [COLOUR_W-1:0] rom_data;
   logic [X_W-1:0]      x_v;
   logic [Y_W-1:0]      y_v;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
      output go, erase, x_in, y_in, rom_data,
      input  rom_addr, x_v, y_v, colour, plot, busy, done
   );

   modport slave (
      input  go, erase, x_in, y_in, rom_data,
      output rom_addr, x_v, y_v, colour, plot, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/sprite_plotter_pixel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scan
//  Description : Raster-order column/row counter over an SPR_W x SPR_H
//                rectangle, with synchronous clear, advance enable and a flag
//                marking the final (bottom-right) position.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_scan #(
   parameter int SPR_W = 8,
   parameter int SPR_H = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_i,
   input  logic       en_i,
   output logic [3:0] col_o,
   output logic [3:0] row_o,
   output logic       last_o
);

   localparam logic [3:0] C_COL_MAX = 4'(SPR_W - 1);
   localparam logic [3:0] C_ROW_MAX = 4'(SPR_H - 1);

   logic [3:0] col_q, col_d;
   logic [3:0] row_q, row_d;
   logic       w_col_wrap;

   assign w_col_wrap = (col_q == C_COL_MAX);

   // Next position: clear wins, otherwise step the column and carry into row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         if (w_col_wrap) begin
            col_d = '0;
            row_d = (row_q == C_ROW_MAX) ? '0 : row_q + 4'd1;
         end else begin
            col_d = col_q + 4'd1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = w_col_wrap && (row_q == C_ROW_MAX);

endmodule
`default_nettype wire

// File: rtl/sprite_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_plotter
//  Description : On a go request, walks an SPR_W x SPR_H sprite in raster
//                order, fetching colour from a 1-cycle-latency sprite ROM
//                (or using BG_COLOUR when erasing) and emitting one pixel
//                write per cycle to the VGA adapter, followed by a done pulse.
//  Config      : SPRITE_CLIP_EN - when defined, pixels falling outside the
//                160x120 screen keep their slot but are not plotted.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_plotter
   import vga_pkg::*;
#(
   parameter int                  SPR_W     = 8,
   parameter int                  SPR_H     = 8,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
   input  logic             clk,
   input  logic             reset,
   sprite_plotter_if.slave  bus
);

   state_t         state_q, state_d;
   logic           erase_q;
   logic [X_W-1:0] x_org_q;
   logic [Y_W-1:0] y_org_q;
   logic [X_W-1:0] x_v_q, x_v_d;
   logic [Y_W-1:0] y_v_q, y_v_d;
   logic           plot_q, plot_d;

   logic [3:0]     w_col;
   logic [3:0]     w_row;
   logic           w_last;
   logic           w_accept;
   logic           w_scan;
   logic           w_vis;

   assign w_accept = (state_q == ST_IDLE) && bus.go;
   assign w_scan   = (state_q == ST_SCAN);

   pixel_scan #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (w_accept),
      .en_i   (w_scan),
      .col_o  (w_col),
      .row_o  (w_row),
      .last_o (w_last)
   );

`ifdef SPRITE_CLIP_EN
   // Widened sums so that positions past the screen edge are seen, not wrapped.
   logic [X_W:0] w_x_sum;
   logic [Y_W:0] w_y_sum;
   assign w_x_sum = {1'b0, x_org_q} + (X_W+1)'(w_col);
   assign w_y_sum = {1'b0, y_org_q} + (Y_W+1)'(w_row);
   assign w_vis   = (w_x_sum < (X_W+1)'(SCREEN_W)) && (w_y_sum < (Y_W+1)'(SCREEN_H));
`else
   logic [X_W-1:0] w_x_sum;
   logic [Y_W-1:0] w_y_sum;
   assign w_x_sum = x_org_q + X_W'(w_col);
   assign w_y_sum = y_org_q + Y_W'(w_row);
   assign w_vis   = 1'b1;
`endif

   // Next state: one SCAN cycle per sprite pixel, then drain and signal.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.go) state_d = ST_SCAN;
         ST_SCAN:  if (w_last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Origin and mode are captured only when a request is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         erase_q <= 1'b0;
         x_org_q <= '0;
         y_org_q <= '0;
      end else if (w_accept) begin
         erase_q <= bus.erase;
         x_org_q <= bus.x_in;
         y_org_q <= bus.y_in;
      end
   end

   // Pixel stage aligned with ROM read data: coordinates of the address just issued.
   always_comb begin
      x_v_d  = w_x_sum[X_W-1:0];
      y_v_d  = w_y_sum[Y_W-1:0];
      plot_d = w_scan && w_vis;
   end

   // Pixel output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_v_q  <= '0;
         y_v_q  <= '0;
         plot_q <= 1'b0;
      end else begin
         x_v_q  <= x_v_d;
         y_v_q  <= y_v_d;
         plot_q <= plot_d;
      end
   end

   // Address is only driven while scanning; idle address rests at zero.
   assign bus.rom_addr = w_scan ? (8'(w_row) * 8'(SPR_W) + 8'(w_col)) : 8'd0;

   // ROM data arrives in the pixel slot itself, so colour is selected here
   // and forced to zero outside plotted slots.
   assign bus.colour = !plot_q ? '0 : (erase_q ? BG_COLOUR : bus.rom_data);
   assign bus.x_v    = x_v_q;
   assign bus.y_v    = y_v_q;
   assign bus.plot   = plot_q;
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.done   = (state_q == ST_DONE);

endmodule
`default_nettype wire
